// File: rtl/pc_test_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pc_test_monitor                                               |
// | Purpose  : Watches retired PCs of a self-checking test program and       |
// |            reports PASS, FAIL, TIMEOUT or HANG with a RUN cycle count.   |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module pc_test_monitor #(
  parameter int PC_WIDTH   = 32,
  parameter int CNT_WIDTH  = 16,
  parameter int TIMEOUT    = 10000,
  parameter int PASS_HOLD  = 4,
  parameter int HANG_LIMIT = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [PC_WIDTH-1:0]  pass_pc,
  input  logic [PC_WIDTH-1:0]  fail_pc,
  input  logic [PC_WIDTH-1:0]  pc,
  input  logic                 pc_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic [2:0]           status,
  output logic [CNT_WIDTH-1:0] cycles,
  output logic [PC_WIDTH-1:0]  last_pc
);

  localparam int c_hold_w = $clog2(PASS_HOLD + 1);
  localparam int c_hang_w = (HANG_LIMIT > 0) ? $clog2(HANG_LIMIT + 1) : 1;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RUN     = 3'd1,
    S_PASS    = 3'd2,
    S_FAIL    = 3'd3,
    S_TIMEOUT = 3'd4,
    S_HANG    = 3'd5
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [PC_WIDTH-1:0]   r_pass_pc;
  logic [PC_WIDTH-1:0]   r_fail_pc;
  logic [c_hold_w-1:0]   r_hold;
  logic [c_hang_w-1:0]   r_hang;
  logic                  r_seen;
  logic [CNT_WIDTH-1:0]  r_cycles;
  logic [PC_WIDTH-1:0]   r_last_pc;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_pass;
  logic                  r_fail;

  logic                  w_valid;
  logic                  w_is_pass;
  logic                  w_repeat;
  logic                  w_hit_fail;
  logic                  w_hit_pass;
  logic                  w_hit_hang;
  logic                  w_timeout;
  logic                  w_arm;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt == S_RUN);
      r_done  <= (w_state_nxt != S_IDLE) && (w_state_nxt != S_RUN);
      r_pass  <= (w_state_nxt == S_PASS);
      r_fail  <= (w_state_nxt == S_FAIL) || (w_state_nxt == S_TIMEOUT) ||
                 (w_state_nxt == S_HANG);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_arm       = 1'b0;
    w_valid     = (r_state == S_RUN) && pc_valid;
    w_is_pass   = (pc == r_pass_pc);
    w_hit_fail  = w_valid && (pc == r_fail_pc);
    w_hit_pass  = w_valid && w_is_pass && (r_hold == c_hold_w'(PASS_HOLD - 1));
    // The first valid sample after start has nothing to repeat.
    w_repeat    = w_valid && r_seen && (pc == r_last_pc) && !w_is_pass;
    w_hit_hang  = (HANG_LIMIT != 0) && w_repeat &&
                  (r_hang == c_hang_w'(HANG_LIMIT - 1));
    w_timeout   = (r_cycles == CNT_WIDTH'(TIMEOUT - 1));

    case (r_state)
      S_RUN: begin
        if (w_hit_fail)      w_state_nxt = S_FAIL;
        else if (w_hit_pass) w_state_nxt = S_PASS;
        else if (w_hit_hang) w_state_nxt = S_HANG;
        else if (w_timeout)  w_state_nxt = S_TIMEOUT;
      end
      default: begin
        if (start) begin
          w_state_nxt = S_RUN;
          w_arm       = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pass_pc <= '0;
      r_fail_pc <= '0;
      r_hold    <= '0;
      r_hang    <= '0;
      r_seen    <= 1'b0;
      r_cycles  <= '0;
      r_last_pc <= '0;
    end else if (w_arm) begin
      r_pass_pc <= pass_pc;
      r_fail_pc <= fail_pc;
      r_hold    <= '0;
      r_hang    <= '0;
      r_seen    <= 1'b0;
      r_cycles  <= '0;
      r_last_pc <= '0;
    end else if (r_state == S_RUN) begin
      // Counts the terminating edge too, and never wraps.
      r_cycles <= (&r_cycles) ? r_cycles : r_cycles + 1'b1;
      if (pc_valid) begin
        r_last_pc <= pc;
        r_seen    <= 1'b1;
        r_hold    <= w_is_pass ? r_hold + 1'b1 : '0;
        if (HANG_LIMIT != 0)
          r_hang <= w_repeat ? r_hang + 1'b1 : '0;
      end
    end
  end

  assign status  = r_state;
  assign busy    = r_busy;
  assign done    = r_done;
  assign pass    = r_pass;
  assign fail    = r_fail;
  assign cycles  = r_cycles;
  assign last_pc = r_last_pc;

endmodule
`default_nettype wire

// File: tb/tb_pc_test_monitor.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_pc_test_monitor                                            |
// | Purpose  : Scoreboard bench for pc_test_monitor (two parameter sets).    |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_pc_test_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] pass_pc = '0;
  logic [31:0] fail_pc = '0;
  logic [31:0] pc = '0;
  logic        pc_valid = 1'b0;
  logic        sel = 1'b0;

  logic        a_busy, a_done, a_pass, a_fail;
  logic [2:0]  a_status;
  logic [15:0] a_cycles;
  logic [31:0] a_last_pc;
  logic        b_busy, b_done, b_pass, b_fail;
  logic [2:0]  b_status;
  logic [15:0] b_cycles;
  logic [31:0] b_last_pc;

  int tests  = 0;
  int failed = 0;

  typedef struct packed {
    logic [2:0]  st;
    logic [15:0] cyc;
    logic [31:0] lpc;
    logic        b;
    logic        d;
    logic        p;
    logic        f;
  } res_t;

  res_t exp_q[$];

  always #5 clk = ~clk;

  pc_test_monitor #(
    .PC_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT(20), .PASS_HOLD(4), .HANG_LIMIT(8)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .pass_pc(pass_pc), .fail_pc(fail_pc),
    .pc(pc), .pc_valid(pc_valid), .busy(a_busy), .done(a_done), .pass(a_pass),
    .fail(a_fail), .status(a_status), .cycles(a_cycles), .last_pc(a_last_pc)
  );

  pc_test_monitor #(
    .PC_WIDTH(32), .CNT_WIDTH(16), .TIMEOUT(20), .PASS_HOLD(1), .HANG_LIMIT(0)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .pass_pc(pass_pc), .fail_pc(fail_pc),
    .pc(pc), .pc_valid(pc_valid), .busy(b_busy), .done(b_done), .pass(b_pass),
    .fail(b_fail), .status(b_status), .cycles(b_cycles), .last_pc(b_last_pc)
  );

  function automatic res_t cur();
    res_t r;
    r.st  = sel ? b_status  : a_status;
    r.cyc = sel ? b_cycles  : a_cycles;
    r.lpc = sel ? b_last_pc : a_last_pc;
    r.b   = sel ? b_busy    : a_busy;
    r.d   = sel ? b_done    : a_done;
    r.p   = sel ? b_pass    : a_pass;
    r.f   = sel ? b_fail    : a_fail;
    return r;
  endfunction

  function automatic res_t mk(input int st, input int cyc, input logic [31:0] lpc);
    res_t r;
    r.st  = 3'(st);
    r.cyc = 16'(cyc);
    r.lpc = lpc;
    r.b   = (st == 1);
    r.d   = (st >= 2);
    r.p   = (st == 2);
    r.f   = (st >= 3);
    return r;
  endfunction

  function automatic string fmt(input res_t r);
    return $sformatf("st=%0d cyc=%0d last=%h busy=%b done=%b pass=%b fail=%b",
                     r.st, r.cyc, r.lpc, r.b, r.d, r.p, r.f);
  endfunction

  // Stimulus tasks start and end on a falling edge.
  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; pc_valid = 1'b0; pc = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic arm(input logic [31:0] pp, input logic [31:0] fp);
    start = 1'b1; pass_pc = pp; fail_pc = fp; pc_valid = 1'b0;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drive(input logic v, input logic [31:0] p);
    start = 1'b0; pc_valid = v; pc = p;
    @(negedge clk);
  endtask

  task automatic wait_done(input int n);
    res_t r;
    for (int k = 0; k < n; k++) begin
      r = cur();
      if (r.d) break;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    res_t r;
    repeat (2) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      r = cur(); tests++;
      if (r !== '0) begin failed++; $display("FAIL reset_state[%0d]: got %s, expected all zero", s, fmt(r)); end
    end
    rst_n = 1'b1;
    @(negedge clk);
    sel = 1'b0;
    r = cur(); tests++;
    if (r !== '0) begin failed++; $display("FAIL idle_hold: got %s, expected all zero", fmt(r)); end
  endtask

  task automatic test_pass();
    res_t r, e;
    sel = 1'b0; do_reset();
    arm(32'h22CC, 32'h22C8);
    r = cur(); tests++;
    if (r !== mk(1, 0, 0)) begin failed++; $display("FAIL arm_run: got %s, expected %s", fmt(r), fmt(mk(1, 0, 0))); end
    exp_q.push_back(mk(2, 7, 32'h22CC));
    drive(1, 32'h0); drive(1, 32'h4); drive(1, 32'h8);
    repeat (3) drive(1, 32'h22CC);
    r = cur(); tests++;
    if (r.d !== 1'b0) begin failed++; $display("FAIL pass_early: got done=%b, expected 0", r.d); end
    drive(1, 32'h22CC);
    wait_done(4);
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL pass_result: got %s, expected %s", fmt(r), fmt(e)); end
    drive(1, 32'h22C8); drive(1, 32'h0);
    r = cur(); tests++;
    if (r !== e) begin failed++; $display("FAIL pass_frozen: got %s, expected %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_hold_clear();
    res_t r, e;
    sel = 1'b0; do_reset();
    arm(32'h22CC, 32'h22C8);
    exp_q.push_back(mk(2, 8, 32'h22CC));
    repeat (3) drive(1, 32'h22CC);
    drive(1, 32'h0);
    repeat (3) drive(1, 32'h22CC);
    r = cur(); tests++;
    if (r !== mk(1, 7, 32'h22CC)) begin failed++; $display("FAIL hold_cleared: got %s, expected %s", fmt(r), fmt(mk(1, 7, 32'h22CC))); end
    drive(1, 32'h22CC);
    wait_done(4);
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL hold_result: got %s, expected %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_fail();
    res_t r, e;
    sel = 1'b0; do_reset();
    arm(32'h22CC, 32'h22C8);
    exp_q.push_back(mk(3, 5, 32'h22C8));
    drive(1, 32'h0); drive(1, 32'h4); drive(1, 32'h8); drive(1, 32'hC);
    drive(1, 32'h22C8);
    wait_done(4);
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL fail_result: got %s, expected %s", fmt(r), fmt(e)); end
    repeat (4) drive(1, 32'h22CC);
    r = cur(); tests++;
    if (r !== e) begin failed++; $display("FAIL fail_frozen: got %s, expected %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_timeout();
    res_t r, e;
    sel = 1'b0; do_reset();
    arm(32'h22CC, 32'h22C8);
    exp_q.push_back(mk(4, 20, 32'h104C));
    for (int i = 0; i < 40; i++) begin
      r = cur();
      if (r.d) break;
      drive(1, 32'h1000 + 32'(4 * i));
    end
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL timeout_stream: got %s, expected %s", fmt(r), fmt(e)); end

    sel = 1'b1; do_reset();
    arm(32'h22CC, 32'h22C8);
    exp_q.push_back(mk(4, 20, 32'h100));
    for (int i = 0; i < 40; i++) begin
      r = cur();
      if (r.d) break;
      drive(1, 32'h100);
    end
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL timeout_nohang: got %s, expected %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_hang();
    res_t r, e;
    sel = 1'b0; do_reset();
    arm(32'h22CC, 32'h22C8);
    exp_q.push_back(mk(5, 17, 32'h40));
    for (int i = 0; i < 40; i++) begin
      r = cur();
      if (r.d) break;
      drive(i[0] == 1'b0, 32'h40);
    end
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL hang_result: got %s, expected %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_back_to_back();
    res_t r, e;
    sel = 1'b1; do_reset();
    arm(32'h2A7C, 32'h2A7C);
    exp_q.push_back(mk(3, 1, 32'h2A7C));
    drive(1, 32'h2A7C);
    wait_done(4);
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL priority_fail: got %s, expected %s", fmt(r), fmt(e)); end
    arm(32'h2D68, 32'h2D64);
    r = cur(); tests++;
    if (r !== mk(1, 0, 0)) begin failed++; $display("FAIL rearm: got %s, expected %s", fmt(r), fmt(mk(1, 0, 0))); end
    exp_q.push_back(mk(2, 2, 32'h2D68));
    drive(1, 32'h2A7C);
    drive(1, 32'h2D68);
    wait_done(4);
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL rearm_pass: got %s, expected %s", fmt(r), fmt(e)); end
  endtask

  task automatic test_async_reset();
    res_t r;
    sel = 1'b0; do_reset();
    arm(32'h22CC, 32'h22C8);
    drive(1, 32'h4); drive(1, 32'h8);
    r = cur(); tests++;
    if (r !== mk(1, 2, 32'h8)) begin failed++; $display("FAIL pre_reset: got %s, expected %s", fmt(r), fmt(mk(1, 2, 32'h8))); end
    #2 rst_n = 1'b0;
    #1 r = cur(); tests++;
    if (r !== '0) begin failed++; $display("FAIL async_reset: got %s, expected all zero", fmt(r)); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_start_in_run();
    res_t r, e;
    sel = 1'b0; do_reset();
    arm(32'h22CC, 32'h22C8);
    drive(1, 32'h0); drive(1, 32'h4);
    start = 1'b1; pass_pc = 32'h40; fail_pc = 32'h44; pc_valid = 1'b1; pc = 32'h8;
    @(negedge clk);
    start = 1'b0;
    r = cur(); tests++;
    if (r !== mk(1, 3, 32'h8)) begin failed++; $display("FAIL start_ignored: got %s, expected %s", fmt(r), fmt(mk(1, 3, 32'h8))); end
    drive(1, 32'h44);
    r = cur(); tests++;
    if (r !== mk(1, 4, 32'h44)) begin failed++; $display("FAIL addr_kept: got %s, expected %s", fmt(r), fmt(mk(1, 4, 32'h44))); end
    exp_q.push_back(mk(3, 5, 32'h22C8));
    drive(1, 32'h22C8);
    wait_done(4);
    r = cur(); e = exp_q.pop_front(); tests++;
    if (r !== e) begin failed++; $display("FAIL orig_fail: got %s, expected %s", fmt(r), fmt(e)); end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_hold_clear();
    test_fail();
    test_timeout();
    test_hang();
    test_back_to_back();
    test_async_reset();
    test_start_in_run();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire

// File: doc/pc_test_monitor.md
Name: pc_test_monitor

Overview:
- Parametrised, synthesizable self-check monitor for the RV32I core's pass/fail test programs.
- Watches the retired PC stream and decides PASS, FAIL, TIMEOUT or HANG; counts cycles.
- Pass/fail addresses are runtime inputs, so one instance serves successive tests such as 0x22C8/0x22CC, 0x2A78/0x2A7C and 0x2D64/0x2D68.
- Sits beside soc.core; outputs feed the bench or board LEDs/UART.

Parameters:
PC_WIDTH, 32, width of PC and address inputs
CNT_WIDTH, 16, width of cycle counter; must hold TIMEOUT
TIMEOUT, 10000, RUN cycles before TIMEOUT is declared
PASS_HOLD, 4, consecutive valid samples at pass_pc required for PASS (>=1)
HANG_LIMIT, 64, consecutive valid repeats of the same non-pass PC that declare HANG; 0 disables hang detection

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; arms a new test
pass_pc  in  PC_WIDTH  pass address, latched on start
fail_pc  in  PC_WIDTH  fail address, latched on start
pc  in  PC_WIDTH  core PC
pc_valid  in  1  pc is a retired/valid sample this cycle
busy  out  1  state is RUN
done  out  1  state is terminal (PASS/FAIL/TIMEOUT/HANG)
pass  out  1  state is PASS
fail  out  1  state is FAIL, TIMEOUT or HANG
status  out  3  0 IDLE, 1 RUN, 2 PASS, 3 FAIL, 4 TIMEOUT, 5 HANG
cycles  out  CNT_WIDTH  RUN cycles elapsed; frozen once terminal
last_pc  out  PC_WIDTH  last valid PC sampled

Behaviour:
- Reset (rst_n low, async): state IDLE. All outputs 0. Latched pass/fail addresses, hold and hang counters cleared. Mid-test reset aborts immediately.
- All outputs are registered. An event sampled at edge N is visible after edge N.
- start:
  - Honoured in IDLE or any terminal state: next state RUN.
  - Clears cycles, hold and hang counters and last_pc; latches pass_pc and fail_pc.
  - Ignored while in RUN.
- In RUN, cycles increments on every edge, including the edge that enters a terminal state. It saturates at all-ones.
- pc is examined only when pc_valid=1. Invalid cycles leave the hold and hang counters unchanged; only the timeout check applies.
- FAIL: valid pc == fail_pc.
- PASS:
  - hold counter increments on a valid pc == pass_pc and clears on a valid pc != pass_pc.
  - PASS is declared on the sample that makes hold == PASS_HOLD. PASS_HOLD=1 means the first hit passes.
- HANG:
  - Condition: valid pc == last_pc and pc != pass_pc increments the hang counter; any other valid sample clears it.
  - HANG is declared when the counter reaches HANG_LIMIT.
  - The first valid sample after start never counts as a repeat.
- TIMEOUT: on the edge where cycles (pre-increment) == TIMEOUT-1, so cycles reads TIMEOUT when done.
- Priority when several conditions hit in one cycle: FAIL > PASS > HANG > TIMEOUT. If pass_pc == fail_pc, the result is FAIL.
- last_pc updates on every valid sample in RUN.
- Terminal states hold until start or reset. pc activity in terminal states is ignored.
- start and a terminal event in the same cycle: the terminal event wins, because start is ignored in RUN.

Test Plan:
1. pass_pc=0x22CC, fail_pc=0x22C8, PASS_HOLD=4. Stream 0,4,8, then 0x22CC every cycle. -> PASS exactly on the 4th 0x22CC sample; status=2, pass=1, cycles=7.
2. Same addresses; stream reaches 0x22C8 on its 5th valid sample. -> FAIL next edge; status=3, fail=1, cycles=5. Subsequent pc ignored.
3. TIMEOUT=20; PC increments by 4 and never hits pass/fail. -> status=4, cycles=20, fail=1. Rerun with HANG_LIMIT=0 and a constant PC of 0x100. -> TIMEOUT again.
4. HANG_LIMIT=8; PC holds 0x40 with pc_valid toggling every other cycle. -> HANG after 8 valid repeats (16 cycles after the first sample); status=5.
5. pass_pc=fail_pc=0x2A7C, PASS_HOLD=1; hit 0x2A7C. -> FAIL (priority). Then pulse start with pass_pc=0x2D68, fail_pc=0x2D64. -> status=1, cycles=0, new addresses used.
6. Assert rst_n low mid-RUN between clock edges. -> outputs 0 and status=0 immediately, with no clock edge. start in RUN mid-test -> no change to cycles.
